// File: rtl/ser_to_para.sv
// Serial-to-parallel receiver: MSB-first bytes, one-cycle done pulses, and 16-byte AES block packing.
// Optional even-parity framing is enabled with `define SER_PARITY_EN.
module ser_to_para #(
  parameter int BYTES = 16
) (
  input  logic                 clk,
  input  logic                 RST,
  input  logic                 enable,
  input  logic                 DataIN,
  output logic [7:0]           DataOUT,
  output logic                 Done_flage,
  output logic [8*BYTES-1:0]   BlockOUT,
  output logic                 Block_done,
  output logic                 Busy,
  output logic                 Parity_err
);

  localparam int CW = (BYTES > 1) ? $clog2(BYTES) : 1;

`ifdef SER_PARITY_EN
  typedef enum logic [1:0] {IDLE, DATA, PAR} state_e;
`else
  typedef enum logic [1:0] {IDLE, DATA} state_e;
`endif

  state_e                  state_q, state_d;
  logic [2:0]              bit_cnt_q, bit_cnt_d;
  logic [7:0]              shift_q, shift_d;
  logic [CW-1:0]           byte_cnt_q, byte_cnt_d;
  logic [BYTES-1:0][7:0]   slots_q, slots_d;
  logic [7:0]              data_out_q, data_out_d;
  logic                    done_q, done_d;
  logic [8*BYTES-1:0]      block_q, block_d;
  logic                    block_done_q, block_done_d;
  logic                    busy_q, busy_d;

  logic                    byte_done;
  logic [7:0]              byte_new;
  logic [8*BYTES-1:0]      block_asm;

`ifdef SER_PARITY_EN
  logic                    par_bad;
  logic                    perr_q, perr_d;
`endif

  // Frame decode kept apart from the main next-state logic so block_asm has no comb loop.
  always_comb begin
    byte_done = 1'b0;
    byte_new  = {shift_q[6:0], DataIN};
`ifdef SER_PARITY_EN
    par_bad   = 1'b0;
    if (enable && state_q == PAR) begin
      byte_done = 1'b1;
      byte_new  = shift_q;
      par_bad   = ^{shift_q, DataIN};
    end
`else
    if (enable && bit_cnt_q == 3'd7) begin
      byte_done = 1'b1;
    end
`endif
  end

  // Full block as it would look with the byte completing now; byte 0 lands in the MSBs.
  for (genvar gi = 0; gi < BYTES; gi++) begin : g_block
    assign block_asm[8*(BYTES-gi)-1 -: 8] =
      (byte_cnt_q == CW'(gi)) ? byte_new : slots_q[gi];
  end

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    byte_cnt_d   = byte_cnt_q;
    slots_d      = slots_q;
    data_out_d   = data_out_q;
    done_d       = 1'b0;
    block_d      = block_q;
    block_done_d = 1'b0;
`ifdef SER_PARITY_EN
    perr_d       = 1'b0;
`endif

    if (enable) begin
      case (state_q)
        IDLE, DATA: begin
          shift_d   = {shift_q[6:0], DataIN};
          bit_cnt_d = bit_cnt_q + 3'd1;
          state_d   = DATA;
          if (bit_cnt_q == 3'd7) begin
`ifdef SER_PARITY_EN
            state_d = PAR;
`else
            state_d = IDLE;
`endif
          end
        end
`ifdef SER_PARITY_EN
        PAR: begin
          state_d = IDLE;
          perr_d  = par_bad;
        end
`endif
        default: state_d = IDLE;
      endcase
    end

    if (byte_done) begin
      data_out_d          = byte_new;
      done_d              = 1'b1;
      slots_d[byte_cnt_q] = byte_new;
      if (byte_cnt_q == CW'(BYTES-1)) begin
        byte_cnt_d   = '0;
        block_d      = block_asm;
        block_done_d = 1'b1;
      end else begin
        byte_cnt_d = byte_cnt_q + CW'(1);
      end
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      byte_cnt_q   <= '0;
      slots_q      <= '0;
      data_out_q   <= '0;
      done_q       <= 1'b0;
      block_q      <= '0;
      block_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      byte_cnt_q   <= byte_cnt_d;
      slots_q      <= slots_d;
      data_out_q   <= data_out_d;
      done_q       <= done_d;
      block_q      <= block_d;
      block_done_q <= block_done_d;
      busy_q       <= busy_d;
    end
  end

`ifdef SER_PARITY_EN
  always_ff @(posedge clk) begin
    if (RST) perr_q <= 1'b0;
    else     perr_q <= perr_d;
  end
  assign Parity_err = perr_q;
`else
  assign Parity_err = 1'b0;
`endif

  assign DataOUT    = data_out_q;
  assign Done_flage = done_q;
  assign BlockOUT   = block_q;
  assign Block_done = block_done_q;
  assign Busy       = busy_q;

endmodule

// File: tb/tb_ser_to_para.sv
// Directed bench for ser_to_para: expected bytes/blocks are queued as stimulus is driven
// and popped whenever the receiver pulses Done_flage / Block_done.
module tb_ser_to_para;
  localparam int BYTES = 16;
`ifdef SER_PARITY_EN
  localparam int FRAME = 9;
`else
  localparam int FRAME = 8;
`endif

  logic                clk = 1'b0;
  logic                RST, enable, DataIN;
  logic [7:0]          DataOUT;
  logic                Done_flage, Block_done, Busy, Parity_err;
  logic [8*BYTES-1:0]  BlockOUT;

  ser_to_para #(.BYTES(BYTES)) dut (
    .clk(clk), .RST(RST), .enable(enable), .DataIN(DataIN),
    .DataOUT(DataOUT), .Done_flage(Done_flage), .BlockOUT(BlockOUT),
    .Block_done(Block_done), .Busy(Busy), .Parity_err(Parity_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_done_cyc = 0;
  int done_count = 0;
  logic prev_done = 1'b0;

  logic [7:0]         exp_byte_q[$];
  logic               exp_perr_q[$];
  logic [8*BYTES-1:0] exp_blk_q[$];
  logic [8*BYTES-1:0] blk_model = '0;
  int                 blk_idx = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock; outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (Done_flage) begin
      done_count++;
      last_done_cyc = cyc;
      check("done_not_consecutive", prev_done, 1'b0);
      if (exp_byte_q.size() == 0) begin
        check("unexpected_done", Done_flage, 1'b0);
      end else begin
        check("DataOUT", DataOUT, exp_byte_q.pop_front());
        check("Parity_err_on_done", Parity_err, exp_perr_q.pop_front());
      end
    end else begin
      check("Parity_err_idle", Parity_err, 1'b0);
    end
    if (Block_done) begin
      check("block_with_done", Done_flage, 1'b1);
      if (exp_blk_q.size() == 0) check("unexpected_block_done", Block_done, 1'b0);
      else                       check("BlockOUT", BlockOUT, exp_blk_q.pop_front());
    end
    prev_done = Done_flage;
  endtask

  task automatic push_exp(input logic [7:0] b, input logic perr);
    exp_byte_q.push_back(b);
    exp_perr_q.push_back(perr);
    blk_model[8*BYTES-1 - 8*blk_idx -: 8] = b;
    if (blk_idx == BYTES-1) begin
      exp_blk_q.push_back(blk_model);
      blk_idx = 0;
    end else begin
      blk_idx++;
    end
  endtask

  task automatic send_bit(input logic b);
    DataIN = b;
    enable = 1'b1;
    tick();
  endtask

  // Sends one frame back-to-back; optional pause of pause_len cycles after pause_at bits.
  task automatic send_byte(input logic [7:0] data, input logic bad_par,
                           input int pause_at, input int pause_len);
    for (int i = 0; i < FRAME; i++) begin
      if (i == pause_at) begin
        enable = 1'b0;
        DataIN = ~DataIN;
        for (int p = 0; p < pause_len; p++) begin
          tick();
          check("busy_in_pause", Busy, 1'b1);
        end
      end
      if (i == FRAME-1) push_exp(data, (FRAME == 9) ? bad_par : 1'b0);
      if (i < 8) send_bit(data[7-i]);
      else       send_bit((^data) ^ bad_par);
      if (i < FRAME-1) check("busy_mid_frame", Busy, 1'b1);
      else             check("busy_after_frame", Busy, 1'b0);
    end
    check("byte_delivered", 32'(exp_byte_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    enable = 1'b1;
    DataIN = 1'b1;
    tick();
    tick();
    check("rst_DataOUT", DataOUT, 8'h00);
    check("rst_BlockOUT", BlockOUT, '0);
    check("rst_Busy", Busy, 1'b0);
    check("rst_Done", Done_flage, 1'b0);
    check("rst_Block_done", Block_done, 1'b0);
    RST = 1'b0;
    enable = 1'b0;
    exp_byte_q.delete();
    exp_perr_q.delete();
    exp_blk_q.delete();
    blk_model = '0;
    blk_idx = 0;
  endtask

  initial begin
    int t0, d1;
    logic [8*BYTES-1:0] blk_ref;
    RST = 1'b1; enable = 1'b0; DataIN = 1'b0;
    do_reset();
    tick();

    // 0x2B then 0xC3 back-to-back
    send_byte(8'h2B, 1'b0, -1, 0);
    d1 = last_done_cyc;
    send_byte(8'hC3, 1'b0, -1, 0);
    check("b2b_spacing", 32'(last_done_cyc - d1), 32'(FRAME));

    // 0xC3 with a 5-cycle enable gap after bit 3
    enable = 1'b0;
    tick();
    t0 = cyc;
    send_byte(8'hC3, 1'b0, 3, 5);
    check("pause_done_cycle", 32'(last_done_cyc - t0), 32'(FRAME + 5));
    check("pause_DataOUT_held", DataOUT, 8'hC3);

    // Reset after 4 bits of a byte, then a clean 0x2B
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
    do_reset();
    tick();
    t0 = done_count;
    send_byte(8'h2B, 1'b0, -1, 0);
    enable = 1'b0;
    tick(); tick();
    check("single_done_after_rst", 32'(done_count - t0), 32'd1);
    check("DataOUT_after_rst", DataOUT, 8'h2B);

    // Full block 0x00..0x0F from a clean byte counter
    do_reset();
    for (int b = 0; b < BYTES; b++) send_byte(8'(b), 1'b0, -1, 0);
    blk_ref = 128'h000102030405060708090A0B0C0D0E0F;
    check("block_literal", BlockOUT, blk_ref);
    send_byte(8'hA5, 1'b0, -1, 0);
    check("block_held_17th", BlockOUT, blk_ref);
    for (int b = 1; b < BYTES; b++) send_byte(8'(8'h30 + b), 1'b0, -1, 0);
    check("second_block_delivered", 32'(exp_blk_q.size()), 32'd0);

`ifdef SER_PARITY_EN
    send_byte(8'h2B, 1'b0, -1, 0);
    send_byte(8'h2B, 1'b1, -1, 0);
    check("bad_parity_DataOUT", DataOUT, 8'h2B);
`endif

    enable = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("no_pending_bytes", 32'(exp_byte_q.size()), 32'd0);
    check("no_pending_blocks", 32'(exp_blk_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
